branch_predictor: RTL
=====================

# branch_predictor

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. It sits beside the fetch stage of the RISC-V core. Fetch looks up the current `pc` combinationally to get a predicted next PC. The execute stage reports each resolved branch outcome back one entry per cycle. The block also keeps saturating branch and mispredict statistics, which benches read out alongside the register file.

## Interface
- `ENTRIES`, 16: number of BTB entries; power of two, ≥2. `IDX = log2(ENTRIES)`.
- `COUNTER_BITS`, 2: direction counter width, 1..4. `CMAX = 2^COUNTER_BITS-1`, `WT = 2^(COUNTER_BITS-1)` (weakly taken), `WNT = WT-1`.
- `XLEN`, 32: address width.
- `STAT_BITS`, 16: width of statistics counters.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `lookup_pc`, in, XLEN: fetch PC.
- `pred_hit`, out, 1: valid entry with matching tag.
- `pred_taken`, out, 1: predicted taken.
- `pred_target`, out, XLEN: predicted next PC.
- `resolve_valid`, in, 1: a branch resolved this cycle.
- `resolve_pc`, in, XLEN: PC of the resolved branch.
- `resolve_taken`, in, 1: actual direction.
- `resolve_target`, in, XLEN: actual taken target.
- `resolve_pred_taken`, in, 1: prediction carried down the pipe.
- `resolve_pred_target`, in, XLEN: predicted next PC carried down the pipe.
- `flush`, in, 1: synchronous invalidate of all entries.
- `mispredict`, out, 1: current resolve was mispredicted.
- `branch_count`, out, STAT_BITS: resolved branches, saturating.
- `mispredict_count`, out, STAT_BITS: mispredicts, saturating.

## Operation
- Index = `pc[IDX+1:2]`. Tag = `pc[XLEN-1:IDX+2]`. `pc[1:0]` is ignored.
- Each entry holds `valid`, `tag`, `target[XLEN]` and `ctr[COUNTER_BITS]`.
- Lookup:
  - `pred_hit` = `valid[idx] && tag[idx]==lookup tag`.
  - `pred_taken` = `pred_hit && ctr[idx][MSB]`.
  - `pred_target` = `target[idx]` if `pred_taken`, else `lookup_pc+4` (modulo 2^XLEN).
- `mispredict` = `resolve_valid && (resolve_taken != resolve_pred_taken || (resolve_taken && resolve_target != resolve_pred_target))`. This is combinational.
- Update when `resolve_valid` is high, applied at the clock edge:
  - Tag hit, taken: `ctr` increments, saturating at `CMAX`; `target` is set to `resolve_target`.
  - Tag hit, not taken: `ctr` decrements, saturating at 0; `target` is unchanged.
  - Miss, taken: allocate (overwrite) the entry. `valid`=1, tag written, `target`=`resolve_target`, `ctr`=`WT`.
  - Miss, not taken: no change.
- Statistics:
  - `branch_count` increments on every `resolve_valid`.
  - `mispredict_count` increments when `mispredict` is high.
  - Both hold at all-ones and never wrap.
- `flush` clears every `valid` bit. Counters, tags, targets and statistics are untouched.
- `flush` and `resolve_valid` in the same cycle: flush wins and no entry is written. Statistics still update.

## Timing
- Reset values: all `valid`=0, all `ctr`=`WNT`, tags and targets 0, both statistics 0.
  - Resulting outputs: `pred_hit`=0, `pred_taken`=0, `pred_target`=`lookup_pc+4`, `mispredict`=0.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Lookup latency is 0 cycles, from registered table state.
- An update becomes visible to lookup on the cycle after the resolve edge. There is no same-cycle bypass: a lookup of the PC being resolved sees the old entry.
- `mispredict` is valid in the same cycle as `resolve_valid`. Statistics reflect it after the edge.
- Aliasing PCs (same index, different tag) evict each other only on a taken miss.
- At most one resolve per cycle. No backpressure.

## Test plan
- Reset, then `lookup_pc`=0x10 → `pred_hit`=0, `pred_taken`=0, `pred_target`=0x14; both statistics 0.
- Resolve pc 0x10, taken, target 0x40, predicted not taken → `mispredict`=1 that cycle. Next cycle, lookup 0x10 gives hit=1, taken=1, target=0x40; `branch_count`=1, `mispredict_count`=1.
- Resolve 0x10 not-taken twice with `COUNTER_BITS`=2 (ctr 2→1→0) → after the first resolve `pred_taken`=0; a third not-taken keeps ctr at 0; three taken resolves bring it back to saturation at 3.
- Alias: after allocating 0x10, resolve 0x50 (same index 4, tag 1) not-taken → 0x10 entry is kept. Resolve 0x50 taken, target 0x80 → lookup 0x10 now misses, and lookup 0x50 predicts 0x80.
- Assert `flush` together with a taken resolve of 0x20 → next cycle all lookups miss, 0x20 is not allocated, and `branch_count` still increments.
- With `STAT_BITS`=4, issue 20 mispredicting resolves → both statistics hold at 0xF. Assert `reset` mid-run between clock edges → all outputs return to reset values immediately.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor: lookup, resolve,
// flush and the statistics readout.
interface branch_predictor_if #(
    parameter int XLEN      = 32,
    parameter int STAT_BITS = 16
);
    logic [XLEN-1:0]      lookup_pc;
    logic                 pred_hit;
    logic                 pred_taken;
    logic [XLEN-1:0]      pred_target;
    logic                 resolve_valid;
    logic [XLEN-1:0]      resolve_pc;
    logic                 resolve_taken;
    logic [XLEN-1:0]      resolve_target;
    logic                 resolve_pred_taken;
    logic [XLEN-1:0]      resolve_pred_target;
    logic                 flush;
    logic                 mispredict;
    logic [STAT_BITS-1:0] branch_count;
    logic [STAT_BITS-1:0] mispredict_count;

    modport master (
        output lookup_pc, resolve_valid, resolve_pc, resolve_taken,
               resolve_target, resolve_pred_taken, resolve_pred_target, flush,
        input  pred_hit, pred_taken, pred_target, mispredict,
               branch_count, mispredict_count
    );

    modport slave (
        input  lookup_pc, resolve_valid, resolve_pc, resolve_taken,
               resolve_target, resolve_pred_taken, resolve_pred_target, flush,
        output pred_hit, pred_taken, pred_target, mispredict,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters and saturating branch/mispredict statistics.
module branch_predictor #(
    parameter int ENTRIES      = 16,
    parameter int COUNTER_BITS = 2,
    parameter int XLEN         = 32,
    parameter int STAT_BITS    = 16
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bp
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    typedef logic [COUNTER_BITS-1:0] ctr_t;

    localparam ctr_t CMAX = '1;
    localparam ctr_t WT   = ctr_t'(1 << (COUNTER_BITS - 1));
    localparam ctr_t WNT  = ctr_t'((1 << (COUNTER_BITS - 1)) - 1);

    logic [ENTRIES-1:0]   valid_q;
    logic [TAGW-1:0]      tag_q    [ENTRIES];
    logic [XLEN-1:0]      target_q [ENTRIES];
    ctr_t                 ctr_q    [ENTRIES];
    logic [STAT_BITS-1:0] branch_count_q;
    logic [STAT_BITS-1:0] mispredict_count_q;

    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic [1:0]      unused_lk_lo;
    logic [IDX-1:0]  rs_idx;
    logic [TAGW-1:0] rs_tag;
    logic [1:0]      unused_rs_lo;
    logic            lk_hit;
    logic            lk_taken;
    logic            rs_hit;
    logic            mispredict;

    assign {lk_tag, lk_idx, unused_lk_lo} = bp.lookup_pc;
    assign {rs_tag, rs_idx, unused_rs_lo} = bp.resolve_pc;

    // Lookup reads only registered table state, so a resolve in flight is not bypassed.
    always_comb begin
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && ctr_q[lk_idx][COUNTER_BITS-1];
        rs_hit   = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
        mispredict = bp.resolve_valid &&
                     ((bp.resolve_taken != bp.resolve_pred_taken) ||
                      (bp.resolve_taken && (bp.resolve_target != bp.resolve_pred_target)));
    end

    assign bp.pred_hit         = lk_hit;
    assign bp.pred_taken       = lk_taken;
    assign bp.pred_target      = lk_taken ? target_q[lk_idx] : bp.lookup_pc + XLEN'(4);
    assign bp.mispredict       = mispredict;
    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;

    // Table update; a flush in the same cycle suppresses any entry write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (bp.flush) begin
            valid_q <= '0;
        end else if (bp.resolve_valid) begin
            if (rs_hit) begin
                if (bp.resolve_taken) begin
                    target_q[rs_idx] <= bp.resolve_target;
                    if (ctr_q[rs_idx] != CMAX) begin
                        ctr_q[rs_idx] <= ctr_q[rs_idx] + 1'b1;
                    end
                end else if (ctr_q[rs_idx] != '0) begin
                    ctr_q[rs_idx] <= ctr_q[rs_idx] - 1'b1;
                end
            end else if (bp.resolve_taken) begin
                valid_q[rs_idx]  <= 1'b1;
                tag_q[rs_idx]    <= rs_tag;
                target_q[rs_idx] <= bp.resolve_target;
                ctr_q[rs_idx]    <= WT;
            end
        end
    end

    // Statistics keep counting through flushes and stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (bp.resolve_valid && (branch_count_q != '1)) begin
                branch_count_q <= branch_count_q + 1'b1;
            end
            if (mispredict && (mispredict_count_q != '1)) begin
                mispredict_count_q <= mispredict_count_q + 1'b1;
            end
        end
    end
endmodule
